// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store; one transaction at a time,
// ack two cycles after the request edge with zero wait states; losing port holds its request, timeout aborts with err.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_ack,
   output logic                    if_err,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_ack,
   output logic                    d_err,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready,
   output logic                    owner
);

   localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

   state_t        state, state_nxt;
   logic          last_grant;
   logic          win;
   logic          any_req;
   logic          abort;
   logic          err_q;
   logic [CW-1:0] wait_cnt;

   assign any_req = if_req | d_req;
   // On a tie the port opposite to the previous winner takes the memory.
   assign win     = d_req & (~if_req | ~last_grant);
   assign abort   = (state == GRANT) & ~mem_ready & TO_EN & (wait_cnt == TO_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   if (mem_ready || abort) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_req = (state == GRANT);
   assign if_ack  = (state == RESP) & ~owner;
   assign d_ack   = (state == RESP) & owner;
   assign if_err  = if_ack & err_q;
   assign d_err   = d_ack & err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         wait_cnt   <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= win;
                  last_grant <= win;
                  wait_cnt   <= '0;
                  err_q      <= 1'b0;
                  if (win) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_be    <= d_be;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_be    <= '1;
                  end
               end
            end
            GRANT: begin
               // A ready on the final allowed cycle completes normally rather than aborting.
               if (mem_ready) begin
                  err_q <= 1'b0;
                  if (!owner)       if_rdata <= mem_rdata;
                  else if (!mem_we) d_rdata  <= mem_rdata;
               end else if (abort) begin
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4; outputs sampled 1ns after the rising edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack, if_err;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack, d_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        owner;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .resetn(resetn),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_d_rdata;
      logic [31:0] exp_if_rdata;
      int          cyc;

      resetn = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
      d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 0;
      tick(); tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_acks", {if_ack, d_ack, if_err, d_err}, 0);
      chk("rst_owner", owner, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      resetn = 1'b1;

      // Tie after reset: fetch, data, fetch, data
      if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80; d_be = 4'hF;
      mem_ready = 1;
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 32'h11110000 + i;
         tick();
         chk("tie_mem_req", mem_req, 1);
         chk("tie_owner", owner, i % 2);
         chk("tie_mem_addr", mem_addr, (i % 2) ? 32'h80 : 32'h40);
         tick();
         chk("tie_acks", {if_ack, d_ack}, (i % 2) ? 2'b01 : 2'b10);
         if (i % 2) chk("tie_d_rdata", d_rdata, 32'h11110000 + i);
         else       chk("tie_if_rdata", if_rdata, 32'h11110000 + i);
         tick();
         chk("tie_idle_after_resp", {mem_req, if_ack, d_ack}, 0);
      end
      exp_d_rdata = 32'h11110003;
      if_req = 0; d_req = 0; mem_ready = 0;
      tick();

      // Single fetch, zero wait states
      if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h00500093;
      tick();
      chk("f_mem_req", mem_req, 1);
      chk("f_mem_fields", {mem_addr, mem_we, mem_be}, {32'h100, 1'b0, 4'hF});
      chk("f_mem_wdata", mem_wdata, 0);
      chk("f_early_ack", if_ack, 0);
      tick();
      chk("f_ack", {if_ack, if_err, d_ack, mem_req}, 4'b1000);
      chk("f_rdata", if_rdata, 32'h00500093);
      exp_if_rdata = 32'h00500093;
      if_req = 0; mem_ready = 0;
      tick();
      chk("f_ack_width", if_ack, 0);

      // Store with three wait states; ready lands on the last allowed cycle
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
      mem_rdata = 32'hBAD0BAD0;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("st_mem_req", mem_req, 1);
         chk("st_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, 32'h2000, 32'hDEADBEEF, 4'h3});
         if (k == 3) mem_ready = 1;
         tick();
      end
      chk("st_ack", {d_ack, d_err, if_ack, mem_req}, 4'b1000);
      chk("st_rdata_kept", d_rdata, exp_d_rdata);
      d_req = 0; d_we = 0; mem_ready = 0;
      tick();
      chk("st_ack_clear", {d_ack, d_err}, 0);

      // Timeout on a fetch: four GRANT cycles then an error ack
      if_req = 1; if_addr = 32'h300; mem_rdata = 32'h12345678;
      tick();
      cyc = 0;
      while (mem_req && cyc < 10) begin
         cyc++;
         tick();
      end
      chk("to_grant_cycles", cyc, 4);
      chk("to_ack_err", {if_ack, if_err, d_ack}, 3'b110);
      chk("to_rdata_kept", if_rdata, exp_if_rdata);
      if_req = 0;
      tick();
      chk("to_clear", {if_ack, if_err}, 0);

      // Data request held through RESP: one regrant, at the IDLE edge only
      d_req = 1; d_we = 0; d_addr = 32'h4000; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk("hold_owner", {mem_req, owner}, 2'b11);
      tick();
      chk("hold_ack", {d_ack, d_err}, 2'b10);
      chk("hold_rdata", d_rdata, 32'hCAFEF00D);
      tick();
      chk("hold_no_grant_in_resp", {mem_req, d_ack}, 0);
      tick();
      chk("hold_regrant", mem_req, 1);
      tick();
      chk("hold_ack2", d_ack, 1);
      d_req = 0;
      tick();
      tick();
      chk("hold_single_regrant", mem_req, 0);

      // Reset while a data transaction waits in GRANT
      d_req = 1; d_addr = 32'h5000; mem_ready = 0;
      tick();
      chk("mr_grant", {mem_req, owner}, 2'b11);
      resetn = 0;
      #1;
      chk("mr_async_clear", {mem_req, if_ack, d_ack, owner}, 0);
      tick();
      chk("mr_held_idle", mem_req, 0);
      resetn = 1; if_req = 1; if_addr = 32'h600; mem_ready = 1; mem_rdata = 32'h0000A5A5;
      tick();
      chk("mr_tie_fetch", {mem_req, owner}, 2'b10);
      chk("mr_addr", mem_addr, 32'h600);
      tick();
      chk("mr_ack", {if_ack, d_ack}, 2'b10);
      chk("mr_rdata", if_rdata, 32'h0000A5A5);
      if_req = 0; d_req = 0; mem_ready = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
